// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads words at pc, hands them to the control unit
// with a run/done handshake, then advances or branches. Stops on HALT_WORD.
module fetch_unit #(
  parameter int                 ADDR_W    = 8,
  parameter int                 INSTR_W   = 16,
  parameter logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF,
  parameter int                 TIMEOUT   = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic               run,
  input  logic               done,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_load_val,
  output logic [ADDR_W-1:0]  pc,
  output logic [15:0]        instr_count,
  output logic               halted,
  output logic               err
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, EXEC, NEXT, HALTED} state_t;

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic       exec_armed;
  logic       timeout_hit;
  logic       is_halt;

  assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));
  assign is_halt     = (mem_rdata == HALT_WORD);
  assign mem_addr    = pc;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = REQ;
      REQ:     state_next = WAIT;
      WAIT: begin
        if (mem_valid)        state_next = is_halt ? HALTED : EXEC;
        else if (timeout_hit) state_next = IDLE;
      end
      EXEC:    if (exec_armed && done) state_next = NEXT;
      NEXT:    state_next = start ? REQ : IDLE;
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  // run and mem_rd are flops loaded from the next state so they are glitch-free
  // and still cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mem_rd      <= 1'b0;
      run         <= 1'b0;
      wait_cnt    <= '0;
      exec_armed  <= 1'b0;
      instruction <= '0;
      pc          <= '0;
      instr_count <= '0;
      halted      <= 1'b0;
      err         <= 1'b0;
    end else begin
      state      <= state_next;
      mem_rd     <= (state_next == REQ);
      run        <= (state_next == EXEC);
      // done only counts from the second EXEC cycle onwards
      exec_armed <= (state == EXEC);
      case (state)
        IDLE: if (start) err <= 1'b0;
        REQ:  wait_cnt <= '0;
        WAIT: begin
          if (mem_valid) begin
            if (is_halt) halted      <= 1'b1;
            else         instruction <= mem_rdata;
          end else if (timeout_hit) begin
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        NEXT: begin
          if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
          pc <= pc_load ? pc_load_val : pc + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
